melody_sequencer: RTL

//  Upstream driver for the NOTE tone generator. Replaces the hand-set SW[6:0] note select:

---
 rtl/melody_pkg.sv | 24 ++
 rtl/melody_rom.sv | 50 +++++
 rtl/melody_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/melody_pkg.sv
// Shared types for the melody sequencer: ROM entry layout, FSM states and marker values.
package melody_pkg;

  typedef struct packed {
    logic [6:0] note;
    logic [4:0] dur;
  } rom_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PLAY,
    GAP,
    FIN
  } state_t;

  localparam logic [4:0] END_DUR   = 5'd0;
  localparam logic [6:0] REST_NOTE = 7'd0;

  function automatic logic is_end(input rom_entry_t e);
    return e.dur == END_DUR;
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Melody table: four melodies of 2**SLOT_W entries each, synchronous read with one cycle of latency.
module melody_rom
  import melody_pkg::*;
#(
  parameter int SLOT_W = 4
) (
  input  logic              clk,
  input  logic [SLOT_W+1:0] addr,
  output rom_entry_t        data
);

  logic [1:0]        mel;
  logic [SLOT_W-1:0] idx;
  rom_entry_t        entry;

  assign mel = addr[SLOT_W+1:SLOT_W];
  assign idx = addr[SLOT_W-1:0];

  // Unlisted slots read as the end marker, so a short melody terminates by itself.
  always_comb begin
    entry = '{note: REST_NOTE, dur: END_DUR};
    case (mel)
      2'd0: begin
        case (int'(idx))
          0:       entry = '{note: 7'd5, dur: 5'd2};
          1:       entry = '{note: 7'd0, dur: 5'd1};
          2:       entry = '{note: 7'd9, dur: 5'd1};
          default: entry = '{note: REST_NOTE, dur: END_DUR};
        endcase
      end
      2'd1: entry = '{note: 7'd3, dur: 5'd1};
      2'd2: entry = '{note: REST_NOTE, dur: END_DUR};
      2'd3: begin
        case (int'(idx))
          0:       entry = '{note: 7'd12, dur: 5'd2};
          1:       entry = '{note: 7'd0,  dur: 5'd1};
          2:       entry = '{note: 7'd14, dur: 5'd1};
          3:       entry = '{note: 7'd16, dur: 5'd4};
          default: entry = '{note: REST_NOTE, dur: END_DUR};
        endcase
      end
      default: entry = '{note: REST_NOTE, dur: END_DUR};
    endcase
  end

  always_ff @(posedge clk) begin
    data <= entry;
  end

endmodule

// File: rtl/melody_sequencer.sv
// Steps through a stored melody and drives NOTE's select/enable with timed notes and gaps.
// Define MELODY_LOOP_EN to add the loop input that restarts a melody at its end.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int TICKS_PER_BEAT = 6_250_000,
  parameter int GAP_TICKS      = 500_000,
  parameter int SLOT_W         = 4
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] melody_sel,
`ifdef MELODY_LOOP_EN
  input  logic       loop,
`endif
  output logic [6:0] note_sel,
  output logic       note_en,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = $clog2(31 * TICKS_PER_BEAT + 1);
  localparam logic [SLOT_W-1:0] IDX_MAX = {SLOT_W{1'b1}};

  state_t            state, next_state;
  logic [SLOT_W-1:0] idx, next_idx;
  logic [1:0]        mel_q, next_mel;
  logic [CNT_W-1:0]  cnt;
  logic [4:0]        dur_q;
  logic              start_q;
  logic              start_rise;
  logic              loop_eff;
  rom_entry_t        rom_q;
  logic [CNT_W-1:0]  play_last;
  logic [CNT_W-1:0]  gap_last;
  logic [6:0]        note_sel_d;
  logic              note_en_d;
  logic              done_d;

`ifdef MELODY_LOOP_EN
  assign loop_eff = loop;
`else
  assign loop_eff = 1'b0;
`endif

  assign start_rise = start & ~start_q;
  // The gap is carved out of the note's beats, so PLAY is shorter than dur beats.
  assign play_last  = CNT_W'(dur_q) * CNT_W'(TICKS_PER_BEAT) - CNT_W'(GAP_TICKS + 1);
  assign gap_last   = CNT_W'(GAP_TICKS - 1);

  // ROM is addressed with next-cycle indices so its data is valid on FETCH entry.
  melody_rom #(
    .SLOT_W(SLOT_W)
  ) u_rom (
    .clk (CLOCK_50),
    .addr({next_mel, next_idx}),
    .data(rom_q)
  );

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    next_idx   = idx;
    next_mel   = mel_q;
    if (stop) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_rise) begin
            next_mel   = melody_sel;
            next_idx   = '0;
            next_state = FETCH;
          end
        end
        FETCH: next_state = is_end(rom_q) ? FIN : PLAY;
        PLAY: begin
          if (cnt == play_last) next_state = GAP;
        end
        GAP: begin
          if (cnt == gap_last) begin
            if (idx == IDX_MAX) begin
              next_state = FIN;
            end else begin
              next_idx   = idx + SLOT_W'(1);
              next_state = FETCH;
            end
          end
        end
        FIN: begin
          if (loop_eff) begin
            next_idx   = '0;
            next_state = FETCH;
          end else begin
            next_state = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    note_sel_d = note_sel;
    note_en_d  = note_en;
    done_d     = 1'b0;
    busy       = (state != IDLE);
    if (stop) begin
      note_sel_d = REST_NOTE;
      note_en_d  = 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (next_state == PLAY) begin
            note_sel_d = rom_q.note;
            note_en_d  = (rom_q.note != REST_NOTE);
          end
        end
        PLAY: begin
          if (next_state == GAP) note_en_d = 1'b0;
        end
        FIN: begin
          if (next_state == IDLE) begin
            done_d     = 1'b1;
            note_sel_d = REST_NOTE;
            note_en_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tick counter restarts on every state change and rests at zero while idle.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      idx     <= '0;
      mel_q   <= '0;
      cnt     <= '0;
      dur_q   <= '0;
      start_q <= 1'b0;
    end else begin
      idx     <= next_idx;
      mel_q   <= next_mel;
      start_q <= start;
      if (state == IDLE || next_state != state) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (state == FETCH && next_state == PLAY) begin
        dur_q <= rom_q.dur;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      note_sel <= REST_NOTE;
      note_en  <= 1'b0;
      done     <= 1'b0;
    end else begin
      note_sel <= note_sel_d;
      note_en  <= note_en_d;
      done     <= done_d;
    end
  end

endmodule
